// File: rtl/video_pointer_sprite.sv
// Pointer sprite source: 32x32 2bpp bitmap, 3-entry RGB444 palette and an
// enable bit behind a 16-bit register bus. Pixel lookup is purely
// combinational from the pointer coordinates and the stored state.
module video_pointer_sprite #(
    parameter logic [11:0] PAL1_RESET = 12'h000,
    parameter logic [11:0] PAL2_RESET = 12'h000,
    parameter logic [11:0] PAL3_RESET = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  pointer_x,
    input  logic [4:0]  pointer_y,
    input  logic        pointer_active,
    output logic [3:0]  pointer_r,
    output logic [3:0]  pointer_g,
    output logic [3:0]  pointer_b,
    output logic        pointer_opaque,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic [7:0]  bus_addr,
    input  logic [15:0] bus_wdata,
    output logic [15:0] bus_rdata,
    output logic        bus_ack
);

    // Each row holds 32 pixels x 2 bits; bus word w of a row is bits [16w+15:16w].
    logic [63:0] bitmap_q [32];
    logic [63:0] bitmap_d [32];
    logic [11:0] pal1_q, pal1_d;
    logic [11:0] pal2_q, pal2_d;
    logic [11:0] pal3_q, pal3_d;
    logic        enable_q, enable_d;
    logic        bus_ack_q, bus_ack_d;
    logic [15:0] bus_rdata_q, bus_rdata_d;

    logic        accept;
    logic        wr;
    logic [15:0] rd_val;
    logic [63:0] pix_row;
    logic [1:0]  code;
    logic [11:0] pix_rgb;
    logic        opaque;

    // Accept a request only when no ack is outstanding, giving one access per two cycles.
    always_comb begin
        accept = bus_sel & ~bus_ack_q;
        wr     = accept & bus_we;
    end

    // Read mux over the address map; unmapped addresses read as zero.
    always_comb begin
        rd_val = '0;
        if (!bus_addr[7]) begin
            rd_val = bitmap_q[bus_addr[6:2]][{bus_addr[1:0], 4'b0000} +: 16];
        end else begin
            case (bus_addr)
                8'h80:   rd_val = {4'h0, pal1_q};
                8'h81:   rd_val = {4'h0, pal2_q};
                8'h82:   rd_val = {4'h0, pal3_q};
                8'h83:   rd_val = {15'h0000, enable_q};
                default: rd_val = '0;
            endcase
        end
    end

    // Next-state for storage and bus response; rdata is zero except in the ack cycle.
    always_comb begin
        bitmap_d    = bitmap_q;
        pal1_d      = pal1_q;
        pal2_d      = pal2_q;
        pal3_d      = pal3_q;
        enable_d    = enable_q;
        bus_ack_d   = accept;
        bus_rdata_d = accept ? rd_val : 16'h0000;
        if (wr) begin
            if (!bus_addr[7]) begin
                bitmap_d[bus_addr[6:2]][{bus_addr[1:0], 4'b0000} +: 16] = bus_wdata;
            end else begin
                case (bus_addr)
                    8'h80:   pal1_d   = bus_wdata[11:0];
                    8'h81:   pal2_d   = bus_wdata[11:0];
                    8'h82:   pal3_d   = bus_wdata[11:0];
                    8'h83:   enable_d = bus_wdata[0];
                    default: ;
                endcase
            end
        end
    end

    // Bitmap storage has no reset; enable=0 after reset masks its contents.
    always_ff @(posedge clk) begin
        bitmap_q <= bitmap_d;
    end

    // Control, palette and bus response registers with async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pal1_q      <= PAL1_RESET;
            pal2_q      <= PAL2_RESET;
            pal3_q      <= PAL3_RESET;
            enable_q    <= 1'b0;
            bus_ack_q   <= 1'b0;
            bus_rdata_q <= 16'h0000;
        end else begin
            pal1_q      <= pal1_d;
            pal2_q      <= pal2_d;
            pal3_q      <= pal3_d;
            enable_q    <= enable_d;
            bus_ack_q   <= bus_ack_d;
            bus_rdata_q <= bus_rdata_d;
        end
    end

    // Zero-latency pixel lookup; code 0 is always transparent.
    always_comb begin
        pix_row = bitmap_q[pointer_y];
        code    = pix_row[{pointer_x, 1'b0} +: 2];
        case (code)
            2'd1:    pix_rgb = pal1_q;
            2'd2:    pix_rgb = pal2_q;
            2'd3:    pix_rgb = pal3_q;
            default: pix_rgb = 12'h000;
        endcase
        opaque = pointer_active & enable_q & (code != 2'd0);
    end

    assign pointer_opaque = opaque;
    assign pointer_r      = opaque ? pix_rgb[11:8] : 4'h0;
    assign pointer_g      = opaque ? pix_rgb[7:4]  : 4'h0;
    assign pointer_b      = opaque ? pix_rgb[3:0]  : 4'h0;
    assign bus_ack        = bus_ack_q;
    assign bus_rdata      = bus_rdata_q;

endmodule

// File: tb/tb_video_pointer_sprite.sv
// Bench for video_pointer_sprite: fixed vector table, hand-written corner
// sequences, then random bus/pixel traffic against a pixel-array model.
module tb_video_pointer_sprite;

    localparam logic [11:0] P1 = 12'h123;
    localparam logic [11:0] P2 = 12'h456;
    localparam logic [11:0] P3 = 12'h789;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  pointer_x = '0;
    logic [4:0]  pointer_y = '0;
    logic        pointer_active = 1'b0;
    logic [3:0]  pointer_r, pointer_g, pointer_b;
    logic        pointer_opaque;
    logic        bus_sel = 1'b0;
    logic        bus_we = 1'b0;
    logic [7:0]  bus_addr = '0;
    logic [15:0] bus_wdata = '0;
    logic [15:0] bus_rdata;
    logic        bus_ack;

    video_pointer_sprite #(.PAL1_RESET(P1), .PAL2_RESET(P2), .PAL3_RESET(P3)) dut (
        .clk(clk), .reset(reset),
        .pointer_x(pointer_x), .pointer_y(pointer_y), .pointer_active(pointer_active),
        .pointer_r(pointer_r), .pointer_g(pointer_g), .pointer_b(pointer_b),
        .pointer_opaque(pointer_opaque),
        .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: pixel codes per (y,x), palette indexed by code, enable.
    logic [1:0]  bmp [32][32];
    logic [11:0] pal [4];
    logic        en;

    function automatic void model_reset();
        pal[0] = 12'h000; pal[1] = P1; pal[2] = P2; pal[3] = P3;
        en = 1'b0;
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [15:0] d);
        if (a < 8'h80) begin
            for (int n = 0; n < 8; n++) bmp[a / 4][(a % 4) * 8 + n] = d[2*n +: 2];
        end else if (a >= 8'h80 && a <= 8'h82) begin
            pal[a - 8'h7F] = d[11:0];
        end else if (a == 8'h83) begin
            en = d[0];
        end
    endfunction

    function automatic logic [15:0] model_read(input logic [7:0] a);
        logic [15:0] v;
        v = 16'h0000;
        if (a < 8'h80) begin
            for (int n = 0; n < 8; n++) v[2*n +: 2] = bmp[a / 4][(a % 4) * 8 + n];
        end else if (a >= 8'h80 && a <= 8'h82) begin
            v = {4'h0, pal[a - 8'h7F]};
        end else if (a == 8'h83) begin
            v = {15'h0000, en};
        end
        return v;
    endfunction

    function automatic logic [12:0] model_pix(input logic [4:0] x, input logic [4:0] y, input logic act);
        logic [1:0] c;
        logic       op;
        c  = bmp[y][x];
        op = act && en && (c != 2'd0);
        return {op, op ? pal[c] : 12'h000};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One complete access: request at negedge, ack expected one cycle later, then idle.
    task automatic bus_op(input logic we, input logic [7:0] a, input logic [15:0] d,
                          output logic [15:0] rd);
        @(negedge clk);
        bus_sel = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        chk("ack_pulse", {31'd0, bus_ack}, 32'd1);
        rd = bus_rdata;
        bus_sel = 1'b0;
        if (we) model_write(a, d);
        @(negedge clk);
        chk("ack_clear", {15'd0, bus_ack, bus_rdata}, 32'd0);
    endtask

    task automatic set_pix(input logic [4:0] x, input logic [4:0] y, input logic act);
        pointer_x = x; pointer_y = y; pointer_active = act;
        #1;
    endtask

    function automatic logic [12:0] dut_pix();
        return {pointer_opaque, pointer_r, pointer_g, pointer_b};
    endfunction

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        cpix;
        logic [4:0]  px;
        logic [4:0]  py;
        logic        act;
        logic        exp_op;
        logic [11:0] exp_rgb;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    logic [15:0] rd;
    logic [7:0]  ra;
    logic [15:0] rw;
    logic [4:0]  rx, ry;
    logic        rt;

    initial begin
        tbl[0]  = '{1'b0, 8'h80, 16'h0000, 16'h0123, 1'b1, 5'd5,  5'd5,  1'b1, 1'b0, 12'h000};
        tbl[1]  = '{1'b0, 8'h83, 16'h0000, 16'h0000, 1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 12'h000};
        tbl[2]  = '{1'b1, 8'h80, 16'h0F00, 16'h0000, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 12'h000};
        tbl[3]  = '{1'b1, 8'h83, 16'h0001, 16'h0000, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 12'h000};
        tbl[4]  = '{1'b1, 8'h00, 16'h0001, 16'h0000, 1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 12'hF00};
        tbl[5]  = '{1'b0, 8'h00, 16'h0000, 16'h0001, 1'b1, 5'd1,  5'd0,  1'b1, 1'b0, 12'h000};
        tbl[6]  = '{1'b1, 8'h7F, 16'hC000, 16'h0000, 1'b1, 5'd31, 5'd31, 1'b1, 1'b1, 12'h789};
        tbl[7]  = '{1'b0, 8'h7F, 16'h0000, 16'hC000, 1'b1, 5'd31, 5'd31, 1'b0, 1'b0, 12'h000};
        tbl[8]  = '{1'b1, 8'h82, 16'hFABC, 16'h0000, 1'b1, 5'd31, 5'd31, 1'b1, 1'b1, 12'hABC};
        tbl[9]  = '{1'b0, 8'h82, 16'h0000, 16'h0ABC, 1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 12'hF00};
        tbl[10] = '{1'b0, 8'h81, 16'h0000, 16'h0456, 1'b1, 5'd30, 5'd31, 1'b1, 1'b0, 12'h000};
        tbl[11] = '{1'b1, 8'h83, 16'h0000, 16'h0000, 1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 12'h000};
        tbl[12] = '{1'b1, 8'h83, 16'hFFFE, 16'h0000, 1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 12'h000};
        tbl[13] = '{1'b1, 8'h83, 16'hFFFF, 16'h0000, 1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 12'hF00};
        tbl[14] = '{1'b0, 8'h83, 16'h0000, 16'h0001, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 12'h000};
        tbl[15] = '{1'b1, 8'h90, 16'hFFFF, 16'h0000, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 12'h000};
        tbl[16] = '{1'b0, 8'h90, 16'h0000, 16'h0000, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 12'h000};

        for (int y = 0; y < 32; y++) for (int x = 0; x < 32; x++) bmp[y][x] = 2'd0;
        model_reset();

        // Reset state: no ack, nothing opaque anywhere while disabled.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ack", {15'd0, bus_ack, bus_rdata}, 32'd0);
        set_pix(5'd0, 5'd0, 1'b1);   chk("rst_pix_0_0", {19'd0, dut_pix()}, 32'd0);
        set_pix(5'd17, 5'd9, 1'b1);  chk("rst_pix_17_9", {19'd0, dut_pix()}, 32'd0);
        set_pix(5'd31, 5'd31, 1'b1); chk("rst_pix_31_31", {19'd0, dut_pix()}, 32'd0);

        // Fixed vectors.
        for (int i = 0; i < NV; i++) begin
            bus_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd);
            if (!tbl[i].we) chk($sformatf("tbl%0d_rdata", i), {16'd0, rd}, {16'd0, tbl[i].exp_rd});
            if (tbl[i].cpix) begin
                set_pix(tbl[i].px, tbl[i].py, tbl[i].act);
                chk($sformatf("tbl%0d_pix", i), {19'd0, dut_pix()},
                    {19'd0, tbl[i].exp_op, tbl[i].exp_rgb});
            end
        end

        // bus_sel held for 6 cycles on an unmapped read: ack every other cycle, rdata 0.
        @(negedge clk);
        bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 8'h90;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_ack", i), {31'd0, bus_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("hold%0d_rdata", i), {16'd0, bus_rdata}, 32'd0);
        end
        bus_sel = 1'b0;
        bus_op(1'b0, 8'h80, 16'h0, rd); chk("hold_pal1", {16'd0, rd}, {16'd0, model_read(8'h80)});
        bus_op(1'b0, 8'h00, 16'h0, rd); chk("hold_bmp0", {16'd0, rd}, {16'd0, model_read(8'h00)});

        // Write to the word under the pointer: old value before the edge, new after.
        @(negedge clk);
        pointer_x = 5'd0; pointer_y = 5'd0; pointer_active = 1'b1;
        bus_sel = 1'b1; bus_we = 1'b1; bus_addr = 8'h00; bus_wdata = 16'h0003;
        #1;
        chk("wr_pix_before", {19'd0, dut_pix()}, {19'd0, model_pix(5'd0, 5'd0, 1'b1)});
        @(posedge clk);
        #1;
        model_write(8'h00, 16'h0003);
        chk("wr_pix_after", {19'd0, dut_pix()}, {19'd0, model_pix(5'd0, 5'd0, 1'b1)});
        @(negedge clk);
        bus_sel = 1'b0;
        @(negedge clk);

        // Random phase: fill the bitmap so every pixel is known, then mixed traffic.
        for (int w = 0; w < 128; w++) bus_op(1'b1, w[7:0], 16'($urandom), rd);
        for (int p = 0; p < 3; p++) bus_op(1'b1, 8'h80 + p[7:0], 16'($urandom), rd);
        bus_op(1'b1, 8'h83, 16'h0001, rd);
        for (int i = 0; i < 400; i++) begin
            ra = 8'($urandom);
            rw = 16'($urandom);
            if (ra == 8'h83 && ($urandom_range(0, 3) != 0)) rw[0] = 1'b1;
            case ($urandom_range(0, 1))
                0: bus_op(1'b1, ra, rw, rd);
                default: begin
                    bus_op(1'b0, ra, 16'h0, rd);
                    chk($sformatf("rnd_rd_%0h", ra), {16'd0, rd}, {16'd0, model_read(ra)});
                end
            endcase
            rx = 5'($urandom); ry = 5'($urandom); rt = ($urandom_range(0, 7) != 0);
            set_pix(rx, ry, rt);
            chk($sformatf("rnd_pix_%0d_%0d", rx, ry), {19'd0, dut_pix()}, {19'd0, model_pix(rx, ry, rt)});
        end

        // Reset while an access is in flight: ack dropped, output blanked at once.
        bus_op(1'b1, 8'h83, 16'h0001, rd);
        bus_op(1'b1, 8'h00, 16'h0003, rd);
        set_pix(5'd0, 5'd0, 1'b1);
        chk("pre_rst_pix", {19'd0, dut_pix()}, {19'd0, model_pix(5'd0, 5'd0, 1'b1)});
        @(negedge clk);
        bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 8'h83;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_inflight_ack", {15'd0, bus_ack, bus_rdata}, 32'd0);
        chk("rst_inflight_pix", {19'd0, dut_pix()}, 32'd0);
        @(negedge clk);
        chk("rst_held_ack", {31'd0, bus_ack}, 32'd0);
        bus_sel = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_post_ack", {31'd0, bus_ack}, 32'd0);
        bus_op(1'b0, 8'h83, 16'h0, rd); chk("rst_enable", {16'd0, rd}, 32'd0);
        bus_op(1'b0, 8'h81, 16'h0, rd); chk("rst_pal2", {16'd0, rd}, {20'd0, P2});
        bus_op(1'b0, 8'h00, 16'h0, rd); chk("rst_bmp_kept", {16'd0, rd}, {16'd0, model_read(8'h00)});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
